// File: rtl/periferico_muldiv_pkg.sv
// Shared definitions for the multiply/divide peripheral: bus map, control/status bits, FSM states.
package periferico_muldiv_pkg;

  localparam logic [4:0] ADDR_A         = 5'h04;
  localparam logic [4:0] ADDR_B         = 5'h08;
  localparam logic [4:0] ADDR_CTRL      = 5'h0C;
  localparam logic [4:0] ADDR_RESULT    = 5'h10;
  localparam logic [4:0] ADDR_STATUS    = 5'h14;
  localparam logic [4:0] ADDR_REMAINDER = 5'h18;

  localparam int CTRL_START  = 0;
  localparam int CTRL_OP     = 1;
  localparam int CTRL_SIGNED = 2;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_DBZ  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/periferico_muldiv_core.sv
// Sequential shift-add multiplier / restoring divider with sign handling and divide-by-zero detection.
module periferico_muldiv_core
  import periferico_muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sgn_q, sgn_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [2*WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  always_comb begin
    a_mag     = (sgn_q && a[WIDTH-1]) ? -a : a;
    b_mag     = (sgn_q && b[WIDTH-1]) ? -b : b;
    // hi holds the partial product (mul) or running remainder (div); lo holds multiplier / dividend bits.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    div_ge    = (div_shift >= {1'b0, dvs_q});

    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sgn_d       = sgn_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dbz_d       = dbz_q;
    result_d    = result_q;
    remainder_d = remainder_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          op_d    = op;
          sgn_d   = sgn;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        neg_res_d = sgn_q & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d = sgn_q & a[WIDTH-1];
        hi_d      = '0;
        lo_d      = a_mag;
        dvs_d     = b_mag;
        cnt_d     = '0;
        if (op_q && (b == '0)) begin
          state_d     = ST_DONE;
          dbz_d       = 1'b1;
          result_d    = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          remainder_d = {{WIDTH{1'b0}}, a};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (op_q) begin
          hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (op_q) begin
          result_d    = {{WIDTH{1'b0}}, (neg_res_q ? -lo_q : lo_q)};
          remainder_d = {{WIDTH{1'b0}}, (neg_rem_q ? -hi_q : hi_q)};
        end else begin
          result_d = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      sgn_q       <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign result    = result_q;
  assign remainder = remainder_q;

endmodule

// File: rtl/periferico_muldiv.sv
// Bus front end of the multiply/divide peripheral: address decode, operand registers and read mux.
module periferico_muldiv
  import periferico_muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               cs,
  input  logic [4:0]         addr,
  input  logic               rd,
  input  logic               wr,
  output logic [2*WIDTH-1:0] d_out
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               wr_en, rd_en, start;
  logic               busy, done, dbz;
  logic [2*WIDTH-1:0] result, remainder;

  // Operands and CTRL are frozen while an operation is in flight.
  always_comb begin
    wr_en = cs & wr & ~busy;
    rd_en = cs & rd & ~wr;
    start = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START];
    a_d   = (wr_en && (addr == ADDR_A)) ? d_in : a_q;
    b_d   = (wr_en && (addr == ADDR_B)) ? d_in : b_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_A:         d_out = {{WIDTH{1'b0}}, a_q};
        ADDR_B:         d_out = {{WIDTH{1'b0}}, b_q};
        ADDR_RESULT:    d_out = result;
        ADDR_REMAINDER: d_out = remainder;
        ADDR_STATUS: begin
          d_out[STAT_DONE] = done;
          d_out[STAT_BUSY] = busy;
          d_out[STAT_DBZ]  = dbz;
        end
        default:        d_out = '0;
      endcase
    end
  end

  periferico_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (d_in[CTRL_OP]),
    .sgn       (d_in[CTRL_SIGNED]),
    .a         (a_q),
    .b         (b_q),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .result    (result),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_periferico_muldiv.sv
// Directed-vector bench for periferico_muldiv at WIDTH=16.
module tb_periferico_muldiv;

  localparam int W = 16;
  localparam logic [4:0] A_A   = 5'h04;
  localparam logic [4:0] A_B   = 5'h08;
  localparam logic [4:0] A_CTL = 5'h0C;
  localparam logic [4:0] A_RES = 5'h10;
  localparam logic [4:0] A_ST  = 5'h14;
  localparam logic [4:0] A_REM = 5'h18;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   d_in;
  logic           cs, rd, wr;
  logic [4:0]     addr;
  logic [2*W-1:0] d_out;

  int checks = 0;
  int errors = 0;

  periferico_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [W-1:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic wait_done(output int cyc);
    logic [31:0] s;
    cyc = 0;
    bus_read(A_ST, s);
    while (!s[0] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      bus_read(A_ST, s);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ctl, input int exp_cyc);
    int cyc;
    bus_write(A_A, a);
    bus_write(A_B, b);
    bus_write(A_CTL, ctl);
    wait_done(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    expect_reg("rst_status", A_ST, 32'h0);
    expect_reg("rst_result", A_RES, 32'h0);
    expect_reg("rst_a", A_A, 32'h0);

    // rd and wr together: write wins, d_out is 0
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_A; d_in = 16'h1234;
    #1 check("rdwr_dout", d_out, 32'h0);
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    expect_reg("rdwr_a", A_A, 32'h0000_1234);
    expect_reg("unmap_ctl", A_CTL, 32'h0);
    expect_reg("unmap_1c", 5'h1C, 32'h0);

    // unsigned multiply
    bus_write(A_A, 16'd934);
    bus_write(A_B, 16'd367);
    bus_write(A_CTL, 16'h1);
    expect_reg("mul_busy", A_ST, 32'h2);
    begin
      int cyc;
      wait_done(cyc);
      check("mul_lat", 32'(cyc), 32'd19);
    end
    expect_reg("mul_res", A_RES, 32'd342778);
    expect_reg("mul_status", A_ST, 32'h1);
    run_op("mul_max", 16'hFFFF, 16'hFFFF, 16'h1, 19);
    expect_reg("mul_max_res", A_RES, 32'hFFFE_0001);

    // unsigned divide
    run_op("div", 16'd1000, 16'd7, 16'h3, 19);
    expect_reg("div_q", A_RES, 32'd142);
    expect_reg("div_r", A_REM, 32'd6);
    run_op("div_ff", 16'hFFFF, 16'h1, 16'h3, 19);
    expect_reg("div_ff_q", A_RES, 32'h0000_FFFF);
    expect_reg("div_ff_r", A_REM, 32'h0);

    // signed
    run_op("smul", 16'hFFF4, 16'd5, 16'h5, 19);
    expect_reg("smul_res", A_RES, 32'hFFFF_FFC4);
    run_op("smul_nn", 16'hFFFD, 16'hFFFC, 16'h5, 19);
    expect_reg("smul_nn_res", A_RES, 32'h0000_000C);
    run_op("smul_min", 16'h8000, 16'h8000, 16'h5, 19);
    expect_reg("smul_min_res", A_RES, 32'h4000_0000);
    run_op("sdiv", 16'hFF9C, 16'd7, 16'h7, 19);
    expect_reg("sdiv_q", A_RES, 32'h0000_FFF2);
    expect_reg("sdiv_r", A_REM, 32'h0000_FFFE);
    run_op("sdiv_min", 16'h8000, 16'hFFFF, 16'h7, 19);
    expect_reg("sdiv_min_q", A_RES, 32'h0000_8000);
    expect_reg("sdiv_min_r", A_REM, 32'h0);
    expect_reg("sdiv_min_st", A_ST, 32'h1);

    // divide by zero
    run_op("dbz", 16'd55, 16'd0, 16'h3, 2);
    expect_reg("dbz_status", A_ST, 32'h5);
    expect_reg("dbz_q", A_RES, 32'h0000_FFFF);
    expect_reg("dbz_r", A_REM, 32'd55);

    // busy protection: writes at cycles 5 and 6 are ignored
    bus_write(A_A, 16'd934);
    bus_write(A_B, 16'd367);
    bus_write(A_CTL, 16'h1);
    repeat (4) @(posedge clk);
    #1;
    bus_write(A_A, 16'd1);
    bus_write(A_CTL, 16'h1);
    expect_reg("busy_status", A_ST, 32'h2);
    expect_reg("busy_res_hold", A_RES, 32'h0000_FFFF);
    expect_reg("busy_a_hold", A_A, 32'd934);
    begin
      int cyc;
      wait_done(cyc);
      check("busy_lat", 32'(cyc), 32'd13);
    end
    expect_reg("busy_res", A_RES, 32'd342778);
    repeat (3) @(posedge clk);
    #1;
    expect_reg("done_sticky", A_ST, 32'h1);

    // reset mid-operation
    bus_write(A_A, 16'd934);
    bus_write(A_B, 16'd367);
    bus_write(A_CTL, 16'h1);
    repeat (7) @(posedge clk);
    #1;
    expect_reg("pre_rst_busy", A_ST, 32'h2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    expect_reg("mrst_status", A_ST, 32'h0);
    expect_reg("mrst_result", A_RES, 32'h0);
    expect_reg("mrst_rem", A_REM, 32'h0);
    expect_reg("mrst_a", A_A, 32'h0);
    run_op("post_rst", 16'd3, 16'd4, 16'h1, 19);
    expect_reg("post_rst_res", A_RES, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
